// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider for RV DIV/DIVU/REM/REMU with RISC-V special cases.
// WIDTH is 64 when BIT_COUNT_64 is defined; DIV_EARLY_OUT_EN enables single-cycle special-case completion.
module div_sequencer #(
`ifdef BIT_COUNT_64
  parameter int WIDTH = 64
`else
  parameter int WIDTH = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       funct,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       funct_q, funct_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             signed_op;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH+1:0] trial_shift;
  logic [WIDTH+1:0] trial_diff;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             fix_special;
  logic             early_hit;

  function automatic logic is_ovf(input logic [1:0] fn, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b);
    return (~fn[0]) && (a == MIN_NEG) && (b == '1);
  endfunction

  // Quotient/remainder for divide-by-zero, signed overflow and a zero dividend.
  function automatic logic [WIDTH-1:0] special_result(input logic [1:0] fn,
                                                      input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    if (b == '0) begin
      r = fn[1] ? a : '1;
    end else if (is_ovf(fn, a, b)) begin
      r = fn[1] ? '0 : a;
    end else begin
      r = '0;
    end
    return r;
  endfunction

`ifdef DIV_EARLY_OUT_EN
  assign early_hit = (opB == '0) || is_ovf(funct, opA, opB) || (opA == '0);
`else
  assign early_hit = 1'b0;
`endif

  assign signed_op   = ~funct_q[0];
  assign abs_a       = (signed_op && opa_q[WIDTH-1]) ? -opa_q : opa_q;
  assign abs_b       = (signed_op && opb_q[WIDTH-1]) ? -opb_q : opb_q;
  // The shifted remainder never exceeds WIDTH+1 significant bits; the extra MSB is the borrow.
  assign trial_shift = {rem_q, quo_q[WIDTH-1]};
  assign trial_diff  = trial_shift - {2'b00, dvs_q};
  assign q_fix       = negq_q ? -quo_q : quo_q;
  assign r_fix       = negr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  assign fix_special = (opb_q == '0) || is_ovf(funct_q, opa_q, opb_q);

  always_comb begin
    state_d  = state_q;
    funct_d  = funct_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          funct_d = funct;
          opa_d   = opA;
          opb_d   = opB;
          if (early_hit) begin
            result_d = special_result(funct, opA, opB);
            state_d  = DONE;
          end else begin
            state_d = PREP;
          end
        end
      end
      PREP: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          quo_d   = abs_a;
          dvs_d   = abs_b;
          rem_d   = '0;
          negq_d  = signed_op & (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]);
          negr_d  = signed_op & opa_q[WIDTH-1];
          cnt_d   = CNT_W'(WIDTH);
          state_d = ITER;
        end
      end
      ITER: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (!trial_diff[WIDTH+1]) begin
            rem_d = trial_diff[WIDTH:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = trial_shift[WIDTH:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (fix_special) begin
            result_d = special_result(funct_q, opa_q, opb_q);
          end else begin
            result_d = funct_q[1] ? r_fix : q_fix;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      funct_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      funct_q  <= funct_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  // Low in DONE so the held instruction advances together with the result.
  assign stall  = ((state_q == IDLE) && start && !flush) ||
                  (state_q == PREP) || (state_q == ITER) || (state_q == FIX);
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle integer divide/remainder controller for the execute stage. It accepts one RV M-extension divide operation (DIV, DIVU, REM, REMU), runs a radix-2 restoring divider for WIDTH iterations, and applies RISC-V sign and special-case rules to the result. While an operation is in flight it holds the pipeline with `stall`, and it releases the result with a one-cycle `done` pulse.

## Interface
- WIDTH, 32, operand and result width; 64 when BIT_COUNT_64 is defined.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- funct  in  2  operation, equal to funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- opA  in  WIDTH  dividend.
- opB  in  WIDTH  divisor.
- flush  in  1  abort the current operation (branch mispredict or trap).
- stall  out  1  hold upstream pipeline stages.
- busy  out  1  an operation is in progress (state is not IDLE).
- done  out  1  one-cycle pulse; `result` is valid.
- result  out  WIDTH  quotient or remainder; held until the next accepted start.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE -> PREP when start=1 and flush=0. On that edge the block latches funct, opA and opB.
- PREP:
  - For signed ops, takes the absolute value of both operands.
  - Records negQ = signA XOR signB and negR = signA. Both are forced to 0 for unsigned ops.
  - Clears the partial remainder (WIDTH+1 bits) and loads the iteration counter with WIDTH.
- ITER, one quotient bit per cycle:
  - Shift {rem, quo} left by 1 and trial-subtract the divisor.
  - If the difference is non-negative, keep it and set the quotient LSB to 1.
  - The counter width is $clog2(WIDTH)+1. Leave ITER when the counter reaches 1 on the same edge as the final iteration.
- FIX:
  - Negate the quotient if negQ and the remainder if negR.
  - Select the quotient for DIV/DIVU or the remainder for REM/REMU, and register it into `result`.
- DONE: done=1 for exactly one cycle, then unconditional transition to IDLE.
- Special cases (results required in both configurations):
  - Divide by zero: quotient = all ones, remainder = opA.
  - Signed overflow (opA = 0x80..0, opB = all ones, DIV/REM): quotient = opA, remainder = 0.
- Flush:
  - In PREP, ITER or FIX: the next edge goes to IDLE, done is not asserted and `result` is unchanged.
  - In DONE: ignored; the pulse completes.
- Simultaneous start and flush in IDLE: flush wins and the start is dropped.
- start outside IDLE is ignored and not queued.
- Reset at any time, including mid-ITER: immediately IDLE. result=0, done=0, busy=0, and stall is 0 unless start is asserted.

## Timing
- Edge 0 is the edge that accepts start.
- State sequence: PREP in cycle 1, ITER in cycles 2..WIDTH+1, FIX in cycle WIDTH+2, DONE in cycle WIDTH+3.
- done is high in cycle WIDTH+3, which is 35 cycles after acceptance for WIDTH=32.
- `stall` is combinational:
  - stall = (start & IDLE & ~flush) | PREP | ITER | FIX.
  - It is low in DONE so the stalled instruction advances with `result` in the same cycle.
- busy is registered state, high from cycle 1 through DONE.
- A new operation may be accepted in the cycle after DONE, with no dead cycle beyond that.

## Configuration
- DIV_EARLY_OUT_EN
- Defined:
  - Divide by zero, signed overflow, and opA = 0 are detected in IDLE on the accepting edge.
  - The next state is DONE directly, so done is high in cycle 1.
  - In that case stall is high only in the accepting cycle (cycle 0).
- Undefined:
  - Every operation takes the full WIDTH+3 cycles.
  - The special-case results above are still forced in FIX, so values are identical and only latency differs.

## Test plan
- DIVU 100/7, then REMU 100/7 (WIDTH=32) -> result 14, then 2; done exactly in cycle 35 after each start; stall low in the done cycle.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); REM 7 / -2 -> 1.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0. With DIV_EARLY_OUT_EN these complete with done in cycle 1; without it, in cycle 35.
- Flush asserted in ITER cycle 10 -> IDLE next edge; no done pulse; result keeps the previous value; a new start the following cycle completes correctly.
- Start held high during busy and in the same cycle as flush -> no extra operations are accepted; exactly one done per accepted start.
- Reset asserted asynchronously mid-ITER -> busy, done and result are 0 immediately; after release, DIVU 9/3 -> 3.
